// File: rtl/prbs64_checker.sv
// Serial checker for the 64-bit XNOR Fibonacci PRBS (taps 64,63,61,60).
// Self-synchronises to the line, then free-runs a local generator and counts errors.
module prbs64_checker #(
   parameter int unsigned LOCK_COUNT  = 128,
   parameter int unsigned WINDOW      = 1024,
   parameter int unsigned UNLOCK_ERRS = 16,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_bit,
   input  logic             in_valid,
   input  logic             clr_counts,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] bit_count
);

   localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned EW = $clog2(UNLOCK_ERRS + 1);

   typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

   state_t          state, state_nxt;
   logic [63:0]     hist;
   logic [6:0]      fill_cnt;
   logic [15:0]     match_cnt;
   logic [WW-1:0]   win_cnt;
   logic [EW-1:0]   win_err;
   logic            pred, hit, err, fill_done, gain, lose, win_end;

   always_comb begin
      pred      = ~(hist[63] ^ hist[62] ^ hist[60] ^ hist[59]);
      err       = (in_bit != pred);
      // all-ones history is the XNOR lockup state and must never count as a match
      hit       = !err && (hist != '1);
      fill_done = in_valid && (fill_cnt == 7'd63);
      gain      = in_valid && hit && (match_cnt == 16'(LOCK_COUNT - 1));
      lose      = in_valid && err && (win_err == EW'(UNLOCK_ERRS - 1));
      win_end   = (win_cnt == WW'(WINDOW - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FILL;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (fill_done) state_nxt = SEARCH;
         SEARCH:  if (gain)      state_nxt = LOCKED;
         LOCKED:  if (lose)      state_nxt = FILL;
         default:                state_nxt = FILL;
      endcase
   end

   always_comb begin
      locked = (state == LOCKED);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist      <= '0;
         fill_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
      end else if (in_valid) begin
         case (state)
            FILL: begin
               hist      <= {hist[62:0], in_bit};
               fill_cnt  <= fill_done ? 7'd0 : fill_cnt + 7'd1;
               match_cnt <= '0;
            end
            SEARCH: begin
               hist      <= {hist[62:0], in_bit};
               match_cnt <= hit ? match_cnt + 16'd1 : 16'd0;
               win_cnt   <= '0;
               win_err   <= '0;
            end
            LOCKED: begin
               // local generator free-runs so a line error never propagates
               hist <= {hist[62:0], pred};
               if (lose) begin
                  fill_cnt  <= '0;
                  match_cnt <= '0;
                  win_cnt   <= '0;
                  win_err   <= '0;
               end else if (win_end) begin
                  win_cnt <= '0;
                  win_err <= '0;
               end else begin
                  win_cnt <= win_cnt + 1'b1;
                  win_err <= win_err + EW'(err);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_pulse <= 1'b0;
         err_count <= '0;
         bit_count <= '0;
      end else begin
         err_pulse <= in_valid && (state == LOCKED) && err;
         if (clr_counts) begin
            err_count <= '0;
            bit_count <= '0;
         end else if (in_valid && (state == LOCKED)) begin
            if (bit_count != '1) bit_count <= bit_count + 1'b1;
            if (err && (err_count != '1)) err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prbs64_checker.sv
// Directed bench for prbs64_checker: lock, error injection, loss/relock,
// control precedence, throttling, lockup guard and counter saturation.
module tb_prbs64_checker;

   localparam logic [63:0] SEED = 64'h0123_4567_89AB_CDEF;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_bit = 1'b0;
   logic        in_valid = 1'b0;
   logic        clr_counts = 1'b0;
   logic        locked, err_pulse;
   logic [31:0] err_count, bit_count;
   logic        locked2, err_pulse2;
   logic [3:0]  err_count2, bit_count2;

   logic [63:0] gen;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   prbs64_checker dut (
      .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
      .clr_counts(clr_counts), .locked(locked), .err_pulse(err_pulse),
      .err_count(err_count), .bit_count(bit_count)
   );

   // narrow-counter instance for saturation and short-lock checks
   prbs64_checker #(.LOCK_COUNT(8), .WINDOW(64), .UNLOCK_ERRS(32), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid),
      .clr_counts(clr_counts), .locked(locked2), .err_pulse(err_pulse2),
      .err_count(err_count2), .bit_count(bit_count2)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic b, input logic v, input logic c);
      @(negedge clk);
      in_bit = b; in_valid = v; clr_counts = c;
      @(posedge clk);
      #1;
   endtask

   task automatic send_gen(input logic flip, input logic c);
      logic nb;
      nb  = ~(gen[63] ^ gen[62] ^ gen[60] ^ gen[59]);
      gen = {gen[62:0], nb};
      step(nb ^ flip, 1'b1, c);
   endtask

   initial begin
      int lock_at, lock2_at, vcount, idle_bad, hi;
      logic pl;
      logic [31:0] pe, pb;

      gen = SEED;
      #1;
      chk("rst_locked", locked, 0);
      chk("rst_pulse", err_pulse, 0);
      chk("rst_errs", err_count, 0);
      chk("rst_bits", bit_count, 0);
      @(negedge clk) reset = 1'b1;

      // clean lock
      lock_at = 0; lock2_at = 0;
      for (int i = 1; i <= 192; i++) begin
         send_gen(1'b0, 1'b0);
         if (locked === 1'b1 && lock_at == 0) lock_at = i;
         if (locked2 === 1'b1 && lock2_at == 0) lock2_at = i;
      end
      chk("lock_at", lock_at, 192);
      chk("lock2_at", lock2_at, 72);

      for (int i = 0; i < 1000; i++) send_gen(1'b0, 1'b0);
      chk("clean_errs", err_count, 0);
      chk("clean_bits", bit_count, 1000);
      chk("sat_bits2", bit_count2, 4'hF);

      // single error
      send_gen(1'b1, 1'b0);
      chk("single_pulse", err_pulse, 1);
      chk("single_errs", err_count, 1);
      chk("single_locked", locked, 1);
      chk("single_errs2", err_count2, 1);
      send_gen(1'b0, 1'b0);
      chk("single_pulse_end", err_pulse, 0);
      for (int i = 0; i < 100; i++) send_gen(1'b0, 1'b0);
      chk("single_no_follow", err_count, 1);
      chk("single_bits", bit_count, 1102);

      // clear on a clean bit
      send_gen(1'b0, 1'b1);
      chk("clr_errs", err_count, 0);
      chk("clr_bits", bit_count, 0);

      // loss of lock: 16 errors, one every 20 bits
      for (int k = 1; k <= 16; k++) begin
         for (int i = 0; i < 19; i++) send_gen(1'b0, 1'b0);
         send_gen(1'b1, 1'b0);
         if (k == 15) chk("loss_hold15", locked, 1);
      end
      chk("loss_locked", locked, 0);
      chk("loss_pulse", err_pulse, 1);
      chk("loss_errs", err_count, 16);
      chk("loss_bits", bit_count, 320);
      chk("sat_errs2", err_count2, 4'hF);
      chk("sat_locked2", locked2, 1);

      // relock, counts preserved
      lock_at = 0;
      for (int i = 1; i <= 192; i++) begin
         send_gen(1'b0, 1'b0);
         if (locked === 1'b1 && lock_at == 0) lock_at = i;
      end
      chk("relock_at", lock_at, 192);
      chk("relock_errs", err_count, 16);
      chk("relock_bits", bit_count, 320);

      // clear coinciding with an error
      send_gen(1'b1, 1'b1);
      chk("clrerr_pulse", err_pulse, 1);
      chk("clrerr_errs", err_count, 0);
      chk("clrerr_bits", bit_count, 0);
      send_gen(1'b1, 1'b0);
      chk("post_clr_errs", err_count, 1);

      // asynchronous reset mid-lock
      #2 reset = 1'b0;
      #1;
      chk("arst_locked", locked, 0);
      chk("arst_pulse", err_pulse, 0);
      chk("arst_errs", err_count, 0);
      chk("arst_bits", bit_count, 0);

      // throttled clean stream
      gen = SEED;
      @(negedge clk) begin in_valid = 1'b0; clr_counts = 1'b0; end
      @(negedge clk) reset = 1'b1;
      vcount = 0; lock_at = 0; idle_bad = 0;
      for (int c = 0; c < 1000 && vcount < 192; c++) begin
         if ($urandom_range(0, 1) == 1) begin
            send_gen(1'b0, 1'b0);
            vcount++;
            if (locked === 1'b1 && lock_at == 0) lock_at = vcount;
         end else begin
            pl = locked; pe = err_count; pb = bit_count;
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (locked !== pl || err_count !== pe || bit_count !== pb || err_pulse !== 1'b0)
               idle_bad++;
         end
      end
      chk("thr_lock_at", lock_at, 192);
      chk("thr_idle", idle_bad, 0);

      // lockup guard: constant ones
      @(negedge clk) reset = 1'b0;
      @(negedge clk) reset = 1'b1;
      hi = 0;
      for (int i = 0; i < 5000; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (locked !== 1'b0) hi++;
      end
      chk("lockup_locked", hi, 0);
      chk("lockup_errs", err_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
